mc_controller_fsm: RTL and testbench

- Multicycle MIPS main controller. It sits directly upstream of the ALU decoder and supplies it the 2-bit aluop.
- Sequences fetch, decode, execute, memory and writeback per instruction from op[5:0].
- Drives all datapath enables and multiplexer selects.
- Adds a memory-ready handshake so fetch and memory states stall on slow memory.

---
 rtl/mc_controller_fsm.sv | 179 +++++++++++++++++
 tb/tb_mc_controller_fsm.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller_fsm.sv
// rtl/mc_controller_fsm.sv - multicycle MIPS main controller with memory-ready stalls
// Optional BNE support is enabled by defining MC_CONTROLLER_BNE_EN.
module mc_controller_fsm #(
   parameter int OPW = 6,
   parameter int STW = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [OPW-1:0] op,
   input  logic           memready,
   output logic [1:0]     aluop,
   output logic           alusrca,
   output logic [1:0]     alusrcb,
   output logic [1:0]     pcsrc,
   output logic           iord,
   output logic           irwrite,
   output logic           pcwrite,
   output logic           branch,
   output logic           regdst,
   output logic           memtoreg,
   output logic           regwrite,
   output logic           memwrite,
`ifdef MC_CONTROLLER_BNE_EN
   output logic           branchne,
`endif
   output logic           illegal
);

   localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPW-1:0] OP_LW    = 6'b100011;
   localparam logic [OPW-1:0] OP_SW    = 6'b101011;
   localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
   localparam logic [OPW-1:0] OP_J     = 6'b000010;
`ifdef MC_CONTROLLER_BNE_EN
   localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
`endif

   typedef enum logic [STW-1:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ORIEX   = 4'd10,
      IMMWB   = 4'd11,
      JEX     = 4'd12,
      BNEEX   = 4'd13
   } state_t;

   state_t state;
   logic   op_legal;

   assign op_legal = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
                     (op == OP_ADDI) || (op == OP_ORI) || (op == OP_J)
`ifdef MC_CONTROLLER_BNE_EN
                     || (op == OP_BNE)
`endif
                     ;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FETCH;
      end else begin
         case (state)
            FETCH:   if (memready) state <= DECODE;
            DECODE: begin
               case (op)
                  OP_LW, OP_SW: state <= MEMADR;
                  OP_RTYPE:     state <= RTYPEEX;
                  OP_BEQ:       state <= BEQEX;
                  OP_ADDI:      state <= ADDIEX;
                  OP_ORI:       state <= ORIEX;
                  OP_J:         state <= JEX;
`ifdef MC_CONTROLLER_BNE_EN
                  OP_BNE:       state <= BNEEX;
`endif
                  default:      state <= FETCH;
               endcase
            end
            MEMADR:  state <= (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   if (memready) state <= MEMWB;
            MEMWR:   if (memready) state <= FETCH;
            RTYPEEX: state <= RTYPEWB;
            ADDIEX:  state <= IMMWB;
            ORIEX:   state <= IMMWB;
            default: state <= FETCH;
         endcase
      end
   end

   // Memory-facing strobes are qualified by memready so a stalled access never commits.
   always_comb begin
      aluop    = 2'b00;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      pcsrc    = 2'b00;
      iord     = 1'b0;
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      illegal  = 1'b0;
`ifdef MC_CONTROLLER_BNE_EN
      branchne = 1'b0;
`endif
      case (state)
         FETCH: begin
            alusrcb = 2'b01;
            irwrite = memready;
            pcwrite = memready;
         end
         DECODE: begin
            alusrcb = 2'b11;
            illegal = !op_legal;
         end
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         MEMRD:   iord = 1'b1;
         MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         MEMWR: begin
            iord     = 1'b1;
            memwrite = memready;
         end
         RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         RTYPEWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         BEQEX: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            branch  = 1'b1;
         end
         ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         ORIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            aluop   = 2'b11;
         end
         IMMWB:   regwrite = 1'b1;
         JEX: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
`ifdef MC_CONTROLLER_BNE_EN
         BNEEX: begin
            alusrca  = 1'b1;
            aluop    = 2'b01;
            pcsrc    = 2'b01;
            branchne = 1'b1;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mc_controller_fsm.sv
// tb/tb_mc_controller_fsm.sv - randomized bench for mc_controller_fsm against a per-instruction cycle model
module tb_mc_controller_fsm;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BNE   = 6'b000101;

   localparam logic [9:0] F_IORD = 10'b1000000000;
   localparam logic [9:0] F_IRW  = 10'b0100000000;
   localparam logic [9:0] F_PCW  = 10'b0010000000;
   localparam logic [9:0] F_BR   = 10'b0001000000;
   localparam logic [9:0] F_RD   = 10'b0000100000;
   localparam logic [9:0] F_M2R  = 10'b0000010000;
   localparam logic [9:0] F_RW   = 10'b0000001000;
   localparam logic [9:0] F_MW   = 10'b0000000100;
   localparam logic [9:0] F_ILL  = 10'b0000000010;
   localparam logic [9:0] F_BNE  = 10'b0000000001;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       memready = 1'b0;
   logic [5:0] op = 6'b0;
   logic [1:0] aluop, alusrcb, pcsrc;
   logic       alusrca, iord, irwrite, pcwrite, branch, regdst, memtoreg, regwrite, memwrite, illegal;
   logic       bne;
   logic [16:0] obs;

   int errors = 0;
   int checks = 0;

   // Expected trace: per cycle the memready to drive, the op to drive and the output vector.
   logic        mr_q[$];
   logic [5:0]  op_q[$];
   logic [16:0] ex_q[$];

   always #5 clk = ~clk;

   mc_controller_fsm dut (
      .clk(clk),
      .reset(reset),
      .op(op),
      .memready(memready),
      .aluop(aluop),
      .alusrca(alusrca),
      .alusrcb(alusrcb),
      .pcsrc(pcsrc),
      .iord(iord),
      .irwrite(irwrite),
      .pcwrite(pcwrite),
      .branch(branch),
      .regdst(regdst),
      .memtoreg(memtoreg),
      .regwrite(regwrite),
      .memwrite(memwrite),
`ifdef MC_CONTROLLER_BNE_EN
      .branchne(bne),
`endif
      .illegal(illegal)
   );

`ifndef MC_CONTROLLER_BNE_EN
   assign bne = 1'b0;
`endif

   assign obs = {aluop, alusrca, alusrcb, pcsrc, iord, irwrite, pcwrite, branch,
                 regdst, memtoreg, regwrite, memwrite, illegal, bne};

   function automatic logic [16:0] mk(input logic [1:0] aop, input logic sa, input logic [1:0] sb,
                                      input logic [1:0] ps, input logic [9:0] fl);
      return {aop, sa, sb, ps, fl};
   endfunction

   function automatic logic legal(input logic [5:0] o);
      logic l;
      l = (o == OP_RTYPE) || (o == OP_LW) || (o == OP_SW) || (o == OP_BEQ) ||
          (o == OP_ADDI) || (o == OP_ORI) || (o == OP_J);
`ifdef MC_CONTROLLER_BNE_EN
      l = l || (o == OP_BNE);
`endif
      return l;
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // smp marks the cycles where the controller looks at op; elsewhere op is scrambled.
   task automatic push(input logic m, input logic [16:0] e, input logic smp, input logic [5:0] o);
      mr_q.push_back(m);
      ex_q.push_back(e);
      op_q.push_back(smp ? o : 6'($urandom));
   endtask

   // Expected cycle-by-cycle behaviour of one instruction, fs fetch stalls and ms memory stalls.
   task automatic build(input logic [5:0] o, input int fs, input int ms);
      for (int i = 0; i < fs; i++) push(1'b0, mk(2'b00, 1'b0, 2'b01, 2'b00, '0), 1'b0, o);
      push(1'b1, mk(2'b00, 1'b0, 2'b01, 2'b00, F_IRW | F_PCW), 1'b0, o);
      push(rb(), mk(2'b00, 1'b0, 2'b11, 2'b00, legal(o) ? 10'b0 : F_ILL), 1'b1, o);
      if (legal(o)) begin
         case (o)
            OP_LW, OP_SW: begin
               push(rb(), mk(2'b00, 1'b1, 2'b10, 2'b00, '0), 1'b1, o);
               for (int i = 0; i < ms; i++) push(1'b0, mk(2'b00, 1'b0, 2'b00, 2'b00, F_IORD), 1'b0, o);
               if (o == OP_LW) begin
                  push(1'b1, mk(2'b00, 1'b0, 2'b00, 2'b00, F_IORD), 1'b0, o);
                  push(rb(), mk(2'b00, 1'b0, 2'b00, 2'b00, F_M2R | F_RW), 1'b0, o);
               end else begin
                  push(1'b1, mk(2'b00, 1'b0, 2'b00, 2'b00, F_IORD | F_MW), 1'b0, o);
               end
            end
            OP_RTYPE: begin
               push(rb(), mk(2'b10, 1'b1, 2'b00, 2'b00, '0), 1'b0, o);
               push(rb(), mk(2'b00, 1'b0, 2'b00, 2'b00, F_RD | F_RW), 1'b0, o);
            end
            OP_BEQ: push(rb(), mk(2'b01, 1'b1, 2'b00, 2'b01, F_BR), 1'b0, o);
            OP_ADDI, OP_ORI: begin
               push(rb(), mk((o == OP_ORI) ? 2'b11 : 2'b00, 1'b1, 2'b10, 2'b00, '0), 1'b0, o);
               push(rb(), mk(2'b00, 1'b0, 2'b00, 2'b00, F_RW), 1'b0, o);
            end
            OP_J: push(rb(), mk(2'b00, 1'b0, 2'b00, 2'b10, F_PCW), 1'b0, o);
            default: push(rb(), mk(2'b01, 1'b1, 2'b00, 2'b01, F_BNE), 1'b0, o);
         endcase
      end
   endtask

   task automatic clear_q();
      mr_q.delete();
      op_q.delete();
      ex_q.delete();
   endtask

   task automatic step(input logic m, input logic [5:0] o);
      @(posedge clk);
      #1;
      memready = m;
      op = o;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      memready = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== mk(2'b00, 1'b0, 2'b01, 2'b00, '0))
         $display("FAIL reset_idle: got %h expected %h", obs, mk(2'b00, 1'b0, 2'b01, 2'b00, '0));
      if (obs !== mk(2'b00, 1'b0, 2'b01, 2'b00, '0)) errors++;
      memready = 1'b1;
      #1;
      checks++;
      if (obs !== mk(2'b00, 1'b0, 2'b01, 2'b00, F_IRW | F_PCW)) begin
         errors++;
         $display("FAIL reset_ready: got %h expected %h", obs, mk(2'b00, 1'b0, 2'b01, 2'b00, F_IRW | F_PCW));
      end
      memready = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_async_reset();
      clear_q();
      build(OP_RTYPE, 0, 0);
      build(OP_SW, 0, 0);
      for (int k = 0; k < 7; k++) begin
         step(mr_q[0], op_q[0]);
         checks++;
         if (obs !== ex_q[0]) begin
            errors++;
            $display("FAIL async_pre cycle %0d: got %h expected %h", k, obs, ex_q[0]);
         end
         mr_q.delete(0); op_q.delete(0); ex_q.delete(0);
         // Reset lands mid-RTYPEEX (k=2) and mid-MEMWR with memwrite high (k=6).
         if (k == 2 || k == 6) begin
            memready = 1'b1;
            reset = 1'b1;
            #1;
            checks++;
            if (obs !== mk(2'b00, 1'b0, 2'b01, 2'b00, F_IRW | F_PCW)) begin
               errors++;
               $display("FAIL async_reset at %0d: got %h expected %h", k, obs,
                        mk(2'b00, 1'b0, 2'b01, 2'b00, F_IRW | F_PCW));
            end
            memready = 1'b0;
            reset = 1'b0;
            if (k == 2) begin
               clear_q();
               build(OP_SW, 0, 0);
            end
         end
      end
      clear_q();
   endtask

   task automatic test_rtype();
      build(OP_RTYPE, 0, 0);
      for (int k = 0; ex_q.size() > 0; k++) begin
         step(mr_q[0], op_q[0]);
         checks++;
         if (obs !== ex_q[0]) begin
            errors++;
            $display("FAIL rtype cycle %0d: got %h expected %h", k, obs, ex_q[0]);
         end
         mr_q.delete(0); op_q.delete(0); ex_q.delete(0);
      end
   endtask

   task automatic test_lw_stall();
      build(OP_LW, 0, 2);
      for (int k = 0; ex_q.size() > 0; k++) begin
         step(mr_q[0], op_q[0]);
         checks++;
         if (obs !== ex_q[0]) begin
            errors++;
            $display("FAIL lw_stall cycle %0d: got %h expected %h", k, obs, ex_q[0]);
         end
         mr_q.delete(0); op_q.delete(0); ex_q.delete(0);
      end
   endtask

   task automatic test_sw();
      build(OP_SW, 1, 0);
      build(OP_SW, 0, 1);
      for (int k = 0; ex_q.size() > 0; k++) begin
         step(mr_q[0], op_q[0]);
         checks++;
         if (obs !== ex_q[0]) begin
            errors++;
            $display("FAIL sw cycle %0d: got %h expected %h", k, obs, ex_q[0]);
         end
         mr_q.delete(0); op_q.delete(0); ex_q.delete(0);
      end
   endtask

   task automatic test_beq_ori();
      build(OP_BEQ, 0, 0);
      build(OP_ORI, 0, 0);
      build(OP_ADDI, 0, 0);
      build(OP_J, 0, 0);
      for (int k = 0; ex_q.size() > 0; k++) begin
         step(mr_q[0], op_q[0]);
         checks++;
         if (obs !== ex_q[0]) begin
            errors++;
            $display("FAIL beq_ori cycle %0d: got %h expected %h", k, obs, ex_q[0]);
         end
         mr_q.delete(0); op_q.delete(0); ex_q.delete(0);
      end
   endtask

   task automatic test_illegal();
      build(6'b111111, 0, 0);
      build(OP_BNE, 0, 0);
      build(6'b010001, 0, 0);
      for (int k = 0; ex_q.size() > 0; k++) begin
         step(mr_q[0], op_q[0]);
         checks++;
         if (obs !== ex_q[0]) begin
            errors++;
            $display("FAIL illegal cycle %0d: got %h expected %h", k, obs, ex_q[0]);
         end
         mr_q.delete(0); op_q.delete(0); ex_q.delete(0);
      end
   endtask

   task automatic test_random();
      logic [5:0] pool [8];
      pool = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J, OP_BNE};
      for (int n = 0; n < 60; n++) begin
         int sel;
         sel = $urandom_range(0, 8);
         build((sel == 8) ? 6'($urandom) : pool[sel], $urandom_range(0, 2), $urandom_range(0, 2));
      end
      for (int k = 0; ex_q.size() > 0; k++) begin
         step(mr_q[0], op_q[0]);
         checks++;
         if (obs !== ex_q[0]) begin
            errors++;
            $display("FAIL random cycle %0d: got %h expected %h", k, obs, ex_q[0]);
         end
         mr_q.delete(0); op_q.delete(0); ex_q.delete(0);
      end
   endtask

   initial begin
      test_reset();
      test_async_reset();
      test_rtype();
      test_lw_stall();
      test_sw();
      test_beq_ori();
      test_illegal();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
